// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transmit feeder: word width, FSM state type,
// default abort timeout and a saturating timer helper.
package spi_pkg;

    localparam int SPI_WORD_W  = 12;
    localparam int SPI_TIMEOUT = 1023;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } feeder_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/spi_sync_fifo.sv
// Small synchronous FIFO with show-ahead head word and extra-MSB pointers
// for full/empty detection.
module spi_sync_fifo
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_WORD_W,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              push_ok;
    logic              pop_ok;

    // Push is refused when full even if a pop happens in the same cycle.
    assign push_ok = push && !full && rst;
    assign pop_ok  = pop && !empty;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level = wr_ptr_q - rd_ptr_q;
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/spi_tx_feeder.sv
// Buffers host words and hands them one at a time to the SPI master through
// newd/din, using the master's chip select to detect transfer completion.
module spi_tx_feeder
    import spi_pkg::*;
#(
    parameter int DATA_W  = SPI_WORD_W,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = SPI_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    input  logic [DATA_W-1:0]        s_data,
    output logic                     s_ready,
    output logic                     newd,
    output logic [DATA_W-1:0]        din,
    input  logic                     cs,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              sent_cnt,
    output logic                     timeout_err,
    input  logic                     err_clr
);

    localparam logic [15:0] TIMEOUT_V = 16'(TIMEOUT);

    feeder_state_t     state_q, state_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              newd_q, newd_d;
    logic [15:0]       timer_q, timer_d;
    logic [15:0]       sent_q, sent_d;
    logic              err_q, err_d;
    logic              timeout_set;

    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;

    spi_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s_valid),
        .pop   (fifo_pop),
        .wdata (s_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign s_ready     = !fifo_full;
    assign newd        = newd_q;
    assign din         = din_q;
    assign busy        = (state_q != IDLE);
    assign sent_cnt    = sent_q;
    assign timeout_err = err_q;

    always_comb begin
        state_d     = state_q;
        din_d       = din_q;
        newd_d      = newd_q;
        timer_d     = timer_q;
        sent_d      = sent_q;
        err_d       = err_q;
        fifo_pop    = 1'b0;
        timeout_set = 1'b0;

        case (state_q)
            IDLE: begin
                newd_d = 1'b0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    din_d    = fifo_rdata;
                    newd_d   = 1'b1;
                    timer_d  = '0;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (!cs) begin
                    newd_d  = 1'b0;
                    timer_d = '0;
                    state_d = XFER;
                end else if (timer_q == TIMEOUT_V) begin
                    // The master never took the word: drop it and report.
                    newd_d      = 1'b0;
                    timeout_set = 1'b1;
                    state_d     = IDLE;
                end else begin
                    timer_d = sat_inc16(timer_q);
                end
            end
            XFER: begin
                newd_d = 1'b0;
                if (cs) begin
                    sent_d  = sent_q + 16'd1;
                    state_d = IDLE;
                end else if (timer_q == TIMEOUT_V) begin
                    timeout_set = 1'b1;
                    state_d     = IDLE;
                end else begin
                    timer_d = sat_inc16(timer_q);
                end
            end
            default: begin
                newd_d  = 1'b0;
                state_d = IDLE;
            end
        endcase

        // A fresh timeout beats a simultaneous clear.
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (timeout_set) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            din_q   <= '0;
            newd_q  <= 1'b0;
            timer_q <= '0;
            sent_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            din_q   <= din_d;
            newd_q  <= newd_d;
            timer_q <= timer_d;
            sent_q  <= sent_d;
            err_q   <= err_d;
        end
    end

endmodule
